// File: rtl/sram_req_adapter.sv
// Valid/ready front end for a single-port synchronous SRAM macro with one-cycle read latency.
// Read data is captured into a small response FIFO guarded by a credit check at acceptance.
module sram_req_adapter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned RSP_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    input  logic [DATA_WIDTH-1:0] i_req_be,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_sram_ce,
    output logic                  o_sram_we,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [DATA_WIDTH-1:0] o_sram_wdata,
    output logic [DATA_WIDTH-1:0] o_sram_wem,
    input  logic [DATA_WIDTH-1:0] i_sram_q,
    output logic                  o_rd_inflight
);

    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    logic                  r_rd_pending;
    logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
    logic [PTR_W-1:0]      r_rptr;
    logic [PTR_W-1:0]      r_wptr;
    logic [CNT_W-1:0]      r_occ;

    logic                  w_fire;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic [CNT_W:0]        w_credit_used;
    logic                  w_credit_ok;

    // A read reserves a FIFO slot at acceptance so the capture edge can never overflow.
    assign w_credit_used = {1'b0, r_occ} + {{CNT_W{1'b0}}, r_rd_pending};
    assign w_credit_ok   = w_credit_used < (CNT_W + 1)'(RSP_DEPTH);
    assign o_req_ready   = ~rst & (i_req_we ? 1'b1 : w_credit_ok);
    assign w_fire        = i_req_valid & o_req_ready;

    assign o_sram_ce    = w_fire;
    assign o_sram_we    = i_req_we;
    assign o_sram_addr  = i_req_addr;
    assign o_sram_wdata = i_req_wdata;
    assign o_sram_wem   = i_req_we ? i_req_be : '0;

    assign w_push        = r_rd_pending;
    assign w_full        = (r_occ == CNT_W'(RSP_DEPTH));
    assign o_rsp_valid   = (r_occ != '0);
    assign w_pop         = o_rsp_valid & i_rsp_ready;
    assign o_rsp_rdata   = r_mem[r_rptr];
    assign o_rd_inflight = r_rd_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pending <= 1'b0;
        end else begin
            r_rd_pending <= w_fire & ~i_req_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rptr <= '0;
            r_wptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_sram_q;
                r_wptr <= (r_wptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule
